// File: rtl/adc_scan_uart.sv
// -----------------------------------------------------------------------------
// adc_scan_uart
// Scans NUM_CH analog channels through an external mux/ADC and sends each
// sample as an asynchronous serial frame:
//   start(0), DATA_W data bits (MSB or LSB first), optional parity, stop(1).
// The sequencer and transmitter share a one-entry holding register.
// While a frame is being sent, the next channel can be converted.
// The sequencer waits while a sample is still unsent, so no sample is lost.
//
// Ports
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   scan_en    in   1 = keep scanning; 0 = finish current channel then idle
//   eoc        in   ADC end of conversion
//   data_in    in   ADC result, valid with eoc
//   dsr        in   receiver ready, sampled when a frame is about to start
//   mux_en     out  analog mux enable
//   soc        out  start of conversion
//   load_dato  out  one-cycle pulse after data_in is captured
//   canale     out  current channel index
//   data_out   out  serial line, idles high
//   tx_end     out  pulse in the last cycle of the stop bit
//   busy       out  a frame is pending or being transmitted
//   error      out  a pending frame is held back by dsr=0
// -----------------------------------------------------------------------------
module adc_scan_uart #(
    parameter int NUM_CH    = 8,
    parameter int DATA_W    = 8,
    parameter int BIT_DIV   = 105,
    parameter int PARITY    = 0,
    parameter int MSB_FIRST = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              scan_en,
    input  logic              eoc,
    input  logic [DATA_W-1:0] data_in,
    input  logic              dsr,
    output logic              mux_en,
    output logic              soc,
    output logic              load_dato,
    output logic [3:0]        canale,
    output logic              data_out,
    output logic              tx_end,
    output logic              busy,
    output logic              error
);

    localparam int N_BITS = DATA_W + 2 + ((PARITY != 0) ? 1 : 0);
    localparam int CNT_W  = $clog2(DATA_W + 4);
    localparam int DIV_W  = $clog2(BIT_DIV);
    localparam int SH_W   = DATA_W + 2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUX  = 3'd1,
        S_CONV = 3'd2,
        S_LOAD = 3'd3,
        S_WAIT = 3'd4
    } seq_state_t;

    typedef enum logic {
        T_IDLE = 1'b0,
        T_BIT  = 1'b1
    } tx_state_t;

    // Put data bits into transmit order: bit 0 leaves the line first.
    function automatic logic [DATA_W-1:0] f_order(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        r = d;
        if (MSB_FIRST != 0) begin
            for (int i = 0; i < DATA_W; i++) begin
                r[i] = d[DATA_W-1-i];
            end
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Even parity is the XOR of the data bits; odd parity inverts it.
    function automatic logic f_parity(input logic [DATA_W-1:0] d);
        logic p;
        p = ^d;
        if (PARITY == 2) begin
            p = ~p;
        end else begin
            p = ^d;
        end
        return p;
    endfunction

    seq_state_t        r_seq_state, w_seq_nxt;
    tx_state_t         r_tx_state, w_tx_nxt;
    logic [DATA_W-1:0] r_hold;
    logic              r_hold_full, w_hold_full_nxt;
    logic [3:0]        r_canale;
    logic [SH_W-1:0]   r_shift;
    logic [DIV_W-1:0]  r_div;
    logic [CNT_W-1:0]  r_bit;
    logic              r_mux_en, r_soc, r_load_dato;
    logic              r_data_out, r_tx_end, r_busy, r_error;
    logic              w_tx_start, w_div_last, w_bit_last, w_capture;
    logic [SH_W-1:0]   w_frame;

    // Frame bits after the start bit: data, parity (or extra 1), stop.
    assign w_frame    = {1'b1, ((PARITY != 0) ? f_parity(r_hold) : 1'b1), f_order(r_hold)};
    assign w_tx_start = (r_tx_state == T_IDLE) && r_hold_full && dsr;
    assign w_div_last = (r_div == DIV_W'(BIT_DIV - 1));
    assign w_bit_last = (r_bit == CNT_W'(N_BITS - 1));
    assign w_capture  = (r_seq_state == S_CONV) && eoc;

    // Sequencer next-state decode.
    always_comb begin
        w_seq_nxt = r_seq_state;
        case (r_seq_state)
            S_IDLE: if (scan_en) w_seq_nxt = S_MUX; else w_seq_nxt = S_IDLE;
            S_MUX:  w_seq_nxt = S_CONV;
            S_CONV: if (eoc) w_seq_nxt = S_LOAD; else w_seq_nxt = S_CONV;
            S_LOAD: w_seq_nxt = S_WAIT;
            S_WAIT: begin
                if (r_hold_full) begin
                    w_seq_nxt = S_WAIT;
                end else if (scan_en) begin
                    w_seq_nxt = S_MUX;
                end else begin
                    w_seq_nxt = S_IDLE;
                end
            end
            default: w_seq_nxt = S_IDLE;
        endcase
    end

    // Transmitter next-state and holding-register flag decode.
    always_comb begin
        w_tx_nxt        = r_tx_state;
        w_hold_full_nxt = r_hold_full;
        case (r_tx_state)
            T_IDLE: if (w_tx_start) w_tx_nxt = T_BIT; else w_tx_nxt = T_IDLE;
            T_BIT:  if (w_div_last && w_bit_last) w_tx_nxt = T_IDLE; else w_tx_nxt = T_BIT;
            default: w_tx_nxt = T_IDLE;
        endcase
        // Set and clear never coincide: S_LOAD is only reached with the register empty.
        if (r_seq_state == S_LOAD) begin
            w_hold_full_nxt = 1'b1;
        end else if (w_tx_start) begin
            w_hold_full_nxt = 1'b0;
        end else begin
            w_hold_full_nxt = r_hold_full;
        end
    end

    // Sequencer state, mux/conversion strobes, sample capture and channel index.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_seq_state <= S_IDLE;
            r_mux_en    <= 1'b0;
            r_soc       <= 1'b0;
            r_load_dato <= 1'b0;
            r_hold      <= '0;
            r_canale    <= 4'd0;
        end else begin
            r_seq_state <= w_seq_nxt;
            r_mux_en    <= (w_seq_nxt == S_MUX) || (w_seq_nxt == S_CONV);
            r_soc       <= (w_seq_nxt == S_CONV);
            r_load_dato <= w_capture;
            if (w_capture) begin
                r_hold <= data_in;
            end
            if (r_seq_state == S_LOAD) begin
                r_canale <= (r_canale == 4'(NUM_CH - 1)) ? 4'd0 : (r_canale + 4'd1);
            end
        end
    end

    // Holding-register full flag and the registered status outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_full <= 1'b0;
            r_busy      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_hold_full <= w_hold_full_nxt;
            r_busy      <= w_hold_full_nxt || (w_tx_nxt != T_IDLE);
            r_error     <= (r_tx_state == T_IDLE) && r_hold_full && !dsr;
        end
    end

    // Serial shifter: bit divider, bit counter and line driver.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_state <= T_IDLE;
            r_shift    <= '1;
            r_div      <= '0;
            r_bit      <= '0;
            r_data_out <= 1'b1;
            r_tx_end   <= 1'b0;
        end else begin
            r_tx_state <= w_tx_nxt;
            // tx_end is registered, so it is raised one cycle before the stop bit ends.
            r_tx_end   <= (r_tx_state == T_BIT) && w_bit_last && (r_div == DIV_W'(BIT_DIV - 2));
            if (r_tx_state == T_IDLE) begin
                r_div <= '0;
                r_bit <= '0;
                if (w_tx_start) begin
                    r_data_out <= 1'b0;
                    r_shift    <= w_frame;
                end else begin
                    r_data_out <= 1'b1;
                end
            end else if (w_div_last) begin
                r_div <= '0;
                if (w_bit_last) begin
                    r_bit      <= '0;
                    r_data_out <= 1'b1;
                end else begin
                    r_bit      <= r_bit + CNT_W'(1);
                    r_data_out <= r_shift[0];
                    r_shift    <= {1'b1, r_shift[SH_W-1:1]};
                end
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    assign mux_en    = r_mux_en;
    assign soc       = r_soc;
    assign load_dato = r_load_dato;
    assign canale    = r_canale;
    assign data_out  = r_data_out;
    assign tx_end    = r_tx_end;
    assign busy      = r_busy;
    assign error     = r_error;

endmodule

// File: tb/tb_adc_scan_uart.sv
`timescale 1ns/1ps
module tb_adc_scan_uart;

    localparam int NUM_CH = 8, DATA_W = 8, BIT_DIV = 4, PARITY = 1, MSB_FIRST = 1;
    localparam int NB     = DATA_W + 2 + ((PARITY != 0) ? 1 : 0);
    localparam int D2_W   = 5, D2_DIV = 3, D2_PAR = 2, D2_MSB = 0;
    localparam int NB2    = D2_W + 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n, scan_en, eoc, dsr;
    logic [7:0]  data_in;
    logic        mux_en, soc, load_dato, data_out, tx_end, busy, error;
    logic [3:0]  canale;

    logic        scan_en2, eoc2, dsr2;
    logic [4:0]  data_in2;
    logic        mux_en2, soc2, load_dato2, data_out2, tx_end2, busy2, error2;
    logic [3:0]  canale2;

    adc_scan_uart #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .BIT_DIV(BIT_DIV),
                    .PARITY(PARITY), .MSB_FIRST(MSB_FIRST)) u_dut (
        .clock(clock), .reset_n(reset_n), .scan_en(scan_en), .eoc(eoc),
        .data_in(data_in), .dsr(dsr), .mux_en(mux_en), .soc(soc),
        .load_dato(load_dato), .canale(canale), .data_out(data_out),
        .tx_end(tx_end), .busy(busy), .error(error));

    adc_scan_uart #(.NUM_CH(4), .DATA_W(D2_W), .BIT_DIV(D2_DIV),
                    .PARITY(D2_PAR), .MSB_FIRST(D2_MSB)) u_dut2 (
        .clock(clock), .reset_n(reset_n), .scan_en(scan_en2), .eoc(eoc2),
        .data_in(data_in2), .dsr(dsr2), .mux_en(mux_en2), .soc(soc2),
        .load_dato(load_dato2), .canale(canale2), .data_out(data_out2),
        .tx_end(tx_end2), .busy(busy2), .error(error2));

    int pass_cnt = 0, total_cnt = 0;
    int exp_data_q[$];
    int exp_ch_q[$];
    int ch_model = 0, conv_count = 0, frames_done = 0, error_cycles = 0;
    int adc_delay = 2;
    bit adc_stall = 1'b0, adc_force = 1'b0;
    int adc_force_val = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Expected line levels from the start bit onward, one bit per index.
    function automatic logic [31:0] ref_line(input int d, input int w, input int par, input int msb_first);
        logic [31:0] v;
        int n, ones, idx, b;
        v = '0; n = 1; ones = 0;
        for (int i = 0; i < w; i++) begin
            idx = (msb_first != 0) ? (w - 1 - i) : i;
            b = (d >> idx) & 1;
            v[n] = (b == 1);
            ones += b;
            n++;
        end
        if (par != 0) begin
            v[n] = (par == 1) ? ((ones % 2) == 1) : ((ones % 2) == 0);
            n++;
        end
        v[n] = 1'b1;
        return v;
    endfunction

    // ADC model: answers soc after adc_delay cycles and records the expectation.
    initial begin : adc_model
        int soc_cnt, d;
        soc_cnt = 0;
        eoc = 1'b0; data_in = 8'h00;
        forever begin
            @(negedge clock);
            eoc = 1'b0;
            if (reset_n && soc === 1'b1 && !adc_stall) begin
                soc_cnt++;
                if (soc_cnt >= adc_delay) begin
                    if (adc_force) begin
                        d = adc_force_val; adc_force = 1'b0;
                    end else begin
                        d = int'($urandom_range(255, 0));
                    end
                    eoc = 1'b1;
                    data_in = 8'(d);
                    exp_data_q.push_back(d);
                    exp_ch_q.push_back(ch_model);
                    ch_model = (ch_model + 1) % NUM_CH;
                    conv_count++;
                    soc_cnt = 0;
                end
            end else begin
                soc_cnt = 0;
            end
        end
    end

    // Channel monitor: on each capture the channel index must follow the model.
    initial begin : ch_monitor
        int ch;
        forever begin
            @(negedge clock);
            if (reset_n && load_dato === 1'b1) begin
                check("load_expected", (exp_ch_q.size() > 0), 1'b1);
                check("soc_low_on_load", soc, 1'b0);
                if (exp_ch_q.size() > 0) begin
                    ch = exp_ch_q.pop_front();
                    check("canale", canale, ch);
                end
            end
            if (error === 1'b1) error_cycles++;
        end
    end

    // Frame monitor: decodes data_out and compares against the scoreboard.
    initial begin : frame_monitor
        logic [31:0] got, expv;
        int unstable, tx_bad, st_bad, d;
        bit aborted;
        forever begin
            @(negedge clock);
            if (reset_n && data_out === 1'b0) begin
                got = '0; unstable = 0; tx_bad = 0; st_bad = 0; aborted = 1'b0;
                for (int b = 0; b < NB; b++) begin
                    for (int c = 0; c < BIT_DIV; c++) begin
                        if (!(b == 0 && c == 0)) @(negedge clock);
                        if (!reset_n) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (c == 0) got[b] = data_out;
                        else if (data_out !== got[b]) unstable++;
                        if (tx_end !== ((b == NB - 1) && (c == BIT_DIV - 1))) tx_bad++;
                        if (busy !== 1'b1 || error !== 1'b0) st_bad++;
                    end
                    if (aborted) break;
                end
                if (!aborted) begin
                    check("frame_expected", (exp_data_q.size() > 0), 1'b1);
                    if (exp_data_q.size() > 0) begin
                        d = exp_data_q.pop_front();
                        expv = ref_line(d, DATA_W, PARITY, MSB_FIRST);
                        check("frame_bits", got, expv);
                    end
                    check("bit_stable", unstable, 0);
                    check("tx_end_pos", tx_bad, 0);
                    check("busy_error_in_frame", st_bad, 0);
                    frames_done++;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_load(input string tag);
        int n;
        n = 0;
        while (load_dato !== 1'b1 && n < 300) begin
            @(negedge clock); n++;
        end
        check({"load_seen_", tag}, load_dato, 1'b1);
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (data_out !== 1'b0 && n < 300) begin
            @(negedge clock); n++;
        end
        check({"start_seen_", tag}, data_out, 1'b0);
    endtask

    task automatic drain(input string tag);
        int quiet, n;
        quiet = 0; n = 0;
        while (quiet < 20 && n < 2000) begin
            @(negedge clock); n++;
            if (!busy && !mux_en && !soc && data_out === 1'b1) quiet++;
            else quiet = 0;
        end
        check({"drain_", tag}, (quiet >= 20), 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({"rst_data_out_", tag}, data_out, 1'b1);
        check({"rst_mux_en_", tag}, mux_en, 1'b0);
        check({"rst_soc_", tag}, soc, 1'b0);
        check({"rst_load_", tag}, load_dato, 1'b0);
        check({"rst_canale_", tag}, canale, 4'd0);
        check({"rst_tx_end_", tag}, tx_end, 1'b0);
        check({"rst_busy_", tag}, busy, 1'b0);
        check({"rst_error_", tag}, error, 1'b0);
    endtask

    task automatic dut2_frame(input int d);
        logic [31:0] got, expv;
        int n;
        got = '0; n = 0;
        scan_en2 = 1'b1;
        while (soc2 !== 1'b1 && n < 50) begin @(negedge clock); n++; end
        check("d2_soc_seen", soc2, 1'b1);
        repeat (2) @(negedge clock);
        eoc2 = 1'b1; data_in2 = 5'(d);
        @(negedge clock);
        eoc2 = 1'b0; scan_en2 = 1'b0;
        n = 0;
        while (data_out2 !== 1'b0 && n < 50) begin @(negedge clock); n++; end
        check("d2_start_seen", data_out2, 1'b0);
        for (int b = 1; b < NB2; b++) begin
            repeat (D2_DIV) @(negedge clock);
            got[b] = data_out2;
        end
        expv = ref_line(d, D2_W, D2_PAR, D2_MSB);
        check("d2_frame_bits", got, expv);
        n = 0;
        while (busy2 !== 1'b0 && n < 50) begin @(negedge clock); n++; end
        check("d2_idle", busy2, 1'b0);
    endtask

    initial begin : stimulus
        int n, f0, bad;
        reset_n = 1'b0; scan_en = 1'b0; dsr = 1'b1;
        scan_en2 = 1'b0; eoc2 = 1'b0; data_in2 = 5'd0; dsr2 = 1'b1;
        repeat (3) @(negedge clock);
        check_reset_outputs("init");
        reset_n = 1'b1;
        @(negedge clock);

        // First frame 0xA5, latency, channel advance, then a long scan.
        adc_force = 1'b1; adc_force_val = 8'hA5; error_cycles = 0;
        scan_en = 1'b1;
        wait_load("first");
        n = 0;
        while (data_out !== 1'b0 && n < 10) begin @(negedge clock); n++; end
        check("load_to_start", n, 2);
        check("canale_after_first", canale, 4'd1);
        n = 0;
        while (frames_done < 9 && n < 3000) begin @(negedge clock); n++; end
        check("nine_frames", (frames_done >= 9), 1'b1);
        scan_en = 1'b0;
        drain("scan");
        check("frames_eq_conversions", frames_done, conv_count);
        check("no_sample_lost", exp_data_q.size(), 0);
        check("error_during_scan", error_cycles, 0);

        // Receiver not ready: frame stays pending with error raised.
        dsr = 1'b0;
        scan_en = 1'b1;
        wait_load("dsr");
        scan_en = 1'b0;
        repeat (3) @(negedge clock);
        check("dsr_error", error, 1'b1);
        check("dsr_line_idle", data_out, 1'b1);
        check("dsr_busy", busy, 1'b1);
        bad = 0;
        repeat (10) begin
            @(negedge clock);
            if (data_out !== 1'b1 || error !== 1'b1) bad++;
        end
        check("dsr_hold", bad, 0);
        dsr = 1'b1;
        @(negedge clock);
        check("dsr_release_start", data_out, 1'b0);
        check("dsr_release_error", error, 1'b0);
        drain("dsr");
        check("dsr_queue_empty", exp_data_q.size(), 0);

        // ADC never answers: conversion held, nothing loaded; then drop scan_en in S_CONV.
        adc_stall = 1'b1;
        scan_en = 1'b1;
        n = 0;
        while (soc !== 1'b1 && n < 20) begin @(negedge clock); n++; end
        bad = 0;
        repeat (50) begin
            @(negedge clock);
            if (!(soc === 1'b1 && mux_en === 1'b1 && load_dato === 1'b0 && busy === 1'b0)) bad++;
        end
        check("stall_hold", bad, 0);
        f0 = frames_done;
        scan_en = 1'b0;
        adc_stall = 1'b0;
        drain("drop");
        check("drop_frame_sent", frames_done - f0, 1);
        check("drop_busy", busy, 1'b0);

        // Reset in the middle of data bit 3.
        scan_en = 1'b1;
        wait_start("pre_reset");
        repeat (3 * BIT_DIV + 1) @(negedge clock);
        #1 reset_n = 1'b0;
        #1 check_reset_outputs("mid");
        exp_data_q.delete(); exp_ch_q.delete();
        ch_model = 0; conv_count = 0; frames_done = 0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        wait_load("after_reset");
        check("ch0_after_reset", canale, 4'd0);
        n = 0;
        while (frames_done < 1 && n < 300) begin @(negedge clock); n++; end
        check("frame_after_reset", (frames_done >= 1), 1'b1);
        scan_en = 1'b0;
        drain("reset");
        check("reset_queue_empty", exp_data_q.size(), 0);

        // Odd parity, LSB first, 5-bit instance.
        dut2_frame(5'b00011);
        for (int k = 0; k < 3; k++) dut2_frame(int'($urandom_range(31, 0)));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/adc_scan_uart.md
Name: adc_scan_uart

Overview:
- Parametrised multi-channel acquisition-and-transmit block: scans NUM_CH analog channels, runs one conversion handshake per channel, and serialises each sample as an asynchronous serial frame on data_out.
- Generalises the fixed 8-channel / 8-bit / fixed-delay sequencer-plus-transmitter with configurable channel count, sample width, bit period, parity and bit order.
- Adds a scan enable, a busy/tx_end status pair and error recovery.
- Sits between the external ADC/analog mux and the serial line driver.

Parameters:
- NUM_CH, 8, number of channels scanned, 2..16; canale wraps at NUM_CH-1.
- DATA_W, 8, sample width, 5..16.
- BIT_DIV, 105, clocks per serial bit, >=2.
- PARITY, 0, 0 = none, 1 = even, 2 = odd; parity bit follows the data bits.
- MSB_FIRST, 1, 1 = data MSB sent first, 0 = LSB first.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- scan_en  in  1  1 = run scan; 0 = finish current channel, then idle
- eoc  in  1  ADC end-of-conversion, active high
- data_in  in  DATA_W  ADC result, valid when eoc=1
- dsr  in  1  receiver ready; sampled at frame start
- mux_en  out  1  analog mux enable
- soc  out  1  start of conversion
- load_dato  out  1  one-cycle pulse when data_in is captured
- canale  out  4  current channel index
- data_out  out  1  serial line; idles at 1
- tx_end  out  1  one-cycle pulse on the last stop-bit cycle
- busy  out  1  1 while a frame is pending or transmitting
- error  out  1  1 while a pending frame is blocked by dsr=0

Behaviour:
- Reset (async, any state): all outputs 0 except data_out=1. canale=0. Both FSMs go to IDLE. Holding register is empty. The bit counter and divider clear.
- Sequencer FSM states: S_IDLE, S_MUX, S_CONV, S_LOAD, S_WAIT.
  - S_IDLE: if scan_en=1, go to S_MUX.
  - S_MUX: mux_en=1 for 1 settle cycle, then go to S_CONV.
  - S_CONV: mux_en=1, soc=1; stay until eoc=1.
  - On eoc=1: capture data_in into the holding register, pulse load_dato for one cycle, drop soc and mux_en, go to S_LOAD.
  - S_LOAD: set hold_full=1. Advance canale: if canale==NUM_CH-1 it becomes 0, else canale+1. Go to S_WAIT.
  - S_WAIT: stay while hold_full=1. When hold_full=0, go to S_MUX if scan_en=1, else S_IDLE.
  - Because of S_WAIT, the sequencer never overwrites an unsent sample; no overrun is possible.
  - scan_en dropping mid-conversion does not abort; the current sample completes and is transmitted.
- Transmitter FSM states: T_IDLE, T_BIT.
  - In T_IDLE with hold_full=1:
    - if dsr=1: load the shift register with {stop, parity?, data, start}, clear hold_full, error=0, enter T_BIT.
    - if dsr=0: error=1 and the frame stays pending; retry every cycle. error clears in the cycle the frame starts.
  - Start bit = 0; data in MSB_FIRST order; parity = XOR of data bits (inverted for odd); 1 stop bit = 1.
  - Each bit drives data_out for exactly BIT_DIV cycles.
  - Frame length = BIT_DIV*(DATA_W+2+(PARITY!=0)) cycles.
  - tx_end=1 in the final cycle of the stop bit, then return to T_IDLE.
  - A new pending frame may start in the cycle after tx_end, so frames can run back-to-back.
- Latency: hold_full set to first start-bit cycle on data_out is 1 cycle when dsr=1 and the transmitter is idle.
- busy = hold_full | (tx_state != T_IDLE).
- Invariants: tx_end=1 implies error=0; load_dato=1 implies soc=0 in the same cycle; canale < NUM_CH always; data_out=1 whenever the transmitter is idle.
- Counter widths: the bit divider holds BIT_DIV-1 with no overflow. The bit counter is ceil(log2(DATA_W+4)) bits.

Test Plan (NUM_CH=8, DATA_W=8, BIT_DIV=4, PARITY=1, MSB_FIRST=1 unless noted):
- Reset, scan_en=1, eoc=1 two cycles after soc, data_in=8'hA5 → load_dato pulse. Line shows 0 for 4 cycles, then 1,0,1,0,0,1,0,1 for 4 cycles each, parity 0, stop 1. tx_end is at cycle 44 after the start bit begins; canale=1.
- Scan 9 samples → canale sequence 1,2,...,7,0,1; no sample is lost; error stays 0.
- dsr=0 when a frame is pending → error=1 and data_out=1 held. Raise dsr after 10 cycles → start bit the next cycle and error=0.
- Hold eoc=0 for 50 cycles → soc and mux_en stay 1, no load_dato, busy=0.
- Assert reset_n=0 mid data bit 3 → data_out=1, all other outputs 0 and canale=0 immediately. After release and scan_en=1, the first frame is from channel 0.
- PARITY=2, MSB_FIRST=0, DATA_W=5, data_in=5'b00011 → bits 1,1,0,0,0, parity 1, stop 1.
- Drop scan_en during S_CONV → that frame still transmits, then the block idles with busy=0.
